// File: rtl/mc_controller_if.sv
// Control bus between the multicycle controller and the MIPS32 datapath.
// The master side is the controller: it reads the instruction fields and
// the ALU zero flag, and drives every datapath strobe and select.
interface mc_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  modport master (
    input  op, funct, zero,
    output pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, state
  );

  modport slave (
    output op, funct, zero,
    input  pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, state
  );
endinterface

// File: rtl/mc_controller.sv
// Multicycle MIPS32 control unit: a Moore FSM that steps each instruction
// through fetch, decode, execute, memory and writeback, driving datapath
// strobes from the current state only. pcen is the one exception: it folds
// in the live zero flag so a taken beq updates the PC in BRANCH itself.
module mc_controller (
  input  logic            clk,
  input  logic            reset,
  mc_controller_if.master bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     state_q;
  state_t     state_d;
  logic [1:0] aluop;
  logic       pcwrite;
  logic       branch;

  // ALU function from aluop and, for R-type, the funct field.
  // Unknown functs fall back to add so the datapath stays well defined.
  function automatic logic [2:0] alu_decode(input logic [1:0] aop,
                                            input logic [5:0] fn);
    logic [2:0] res;
    res = 3'b010;
    case (aop)
      2'b01: res = 3'b110;
      2'b10: begin
        case (fn)
          6'b100000: res = 3'b010;
          6'b100010: res = 3'b110;
          6'b100100: res = 3'b000;
          6'b100101: res = 3'b001;
          6'b101010: res = 3'b111;
          default:   res = 3'b010;
        endcase
      end
      default: res = 3'b010;
    endcase
    return res;
  endfunction

  // State register; reset drops straight back to FETCH, aborting any writeback.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic; unused encodings recover to FETCH.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEXEC;
          OP_J:         state_d = JUMP;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = (bus.op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:    state_d = MEMWB;
      EXECUTE:  state_d = ALUWB;
      ADDIEXEC: state_d = ADDIWB;
      default:  state_d = FETCH;
    endcase
  end

  // Moore outputs: everything defaults low, each state raises only its own strobes.
  always_comb begin
    bus.iord     = 1'b0;
    bus.memwrite = 1'b0;
    bus.irwrite  = 1'b0;
    bus.regdst   = 1'b0;
    bus.memtoreg = 1'b0;
    bus.regwrite = 1'b0;
    bus.alusrca  = 1'b0;
    bus.alusrcb  = 2'b00;
    bus.pcsrc    = 2'b00;
    aluop        = 2'b00;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    case (state_q)
      FETCH: begin
        bus.alusrcb = 2'b01;
        bus.irwrite = 1'b1;
        pcwrite     = 1'b1;
      end
      DECODE:   bus.alusrcb = 2'b11;
      MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      MEMRD:    bus.iord = 1'b1;
      MEMWB: begin
        bus.memtoreg = 1'b1;
        bus.regwrite = 1'b1;
      end
      MEMWR: begin
        bus.iord     = 1'b1;
        bus.memwrite = 1'b1;
      end
      EXECUTE: begin
        bus.alusrca = 1'b1;
        aluop       = 2'b10;
      end
      ALUWB: begin
        bus.regdst   = 1'b1;
        bus.regwrite = 1'b1;
      end
      BRANCH: begin
        bus.alusrca = 1'b1;
        aluop       = 2'b01;
        bus.pcsrc   = 2'b01;
        branch      = 1'b1;
      end
      ADDIEXEC: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      ADDIWB:   bus.regwrite = 1'b1;
      JUMP: begin
        bus.pcsrc = 2'b10;
        pcwrite   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.alucontrol = alu_decode(aluop, bus.funct);
  assign bus.pcen       = pcwrite | (branch & bus.zero);
  assign bus.state      = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class through
// its state sequence and checks strobes against hand-computed values.
module tb_mc_controller;

  logic clk = 1'b0;
  logic reset;
  int   passed = 0;
  int   total  = 0;

  mc_controller_if bus();

  mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    logic [3:0] seq [0:4];
    logic       e;
    seq = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    reset = 1'b0; bus.op = 6'b101011; bus.funct = 6'd0; bus.zero = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus.state !== 4'd0) $display("FAIL rst_state got=%0d exp=0", bus.state); else passed++;
    total++; if (bus.irwrite !== 1'b1) $display("FAIL rst_irwrite got=%0b exp=1", bus.irwrite); else passed++;
    total++; if (bus.memwrite !== 1'b0) $display("FAIL rst_memwrite got=%0b exp=0", bus.memwrite); else passed++;
    total++; if (bus.pcen !== 1'b1) $display("FAIL rst_pcen got=%0b exp=1", bus.pcen); else passed++;
    total++; if (bus.alusrcb !== 2'b01) $display("FAIL rst_alusrcb got=%0b exp=01", bus.alusrcb); else passed++;
    total++; if (bus.alucontrol !== 3'b010) $display("FAIL rst_alucontrol got=%0b exp=010", bus.alucontrol); else passed++;
    total++; if (bus.regwrite !== 1'b0) $display("FAIL rst_regwrite got=%0b exp=0", bus.regwrite); else passed++;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      e = (seq[i] == 4'd5);
      total++; if (bus.state !== seq[i]) $display("FAIL sw_state[%0d] got=%0d exp=%0d", i, bus.state, seq[i]); else passed++;
      total++; if (bus.memwrite !== e) $display("FAIL sw_memwrite[%0d] got=%0b exp=%0b", i, bus.memwrite, e); else passed++;
      if (e) begin
        total++; if (bus.iord !== 1'b1) $display("FAIL sw_iord got=%0b exp=1", bus.iord); else passed++;
      end
      if (i < 4) @(negedge clk);
    end
  endtask

  task automatic test_lw();
    logic [3:0] seq [0:4];
    seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    bus.op = 6'b100011;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 5; i++) begin
        total++; if (bus.state !== seq[i]) $display("FAIL lw_state[%0d.%0d] got=%0d exp=%0d", r, i, bus.state, seq[i]); else passed++;
        if (i == 3) begin
          total++; if (bus.iord !== 1'b1) $display("FAIL lw_memrd_iord got=%0b exp=1", bus.iord); else passed++;
          total++; if (bus.regwrite !== 1'b0) $display("FAIL lw_memrd_regwrite got=%0b exp=0", bus.regwrite); else passed++;
        end
        if (i == 4) begin
          total++; if (bus.regwrite !== 1'b1) $display("FAIL lw_regwrite got=%0b exp=1", bus.regwrite); else passed++;
          total++; if (bus.memtoreg !== 1'b1) $display("FAIL lw_memtoreg got=%0b exp=1", bus.memtoreg); else passed++;
          total++; if (bus.regdst !== 1'b0) $display("FAIL lw_regdst got=%0b exp=0", bus.regdst); else passed++;
        end
        @(negedge clk);
      end
    end
    total++; if (bus.state !== 4'd0) $display("FAIL lw_end_state got=%0d exp=0", bus.state); else passed++;
  endtask

  task automatic test_rtype();
    logic [5:0] fn  [0:2];
    logic [2:0] alu [0:2];
    logic [3:0] seq [0:3];
    fn  = '{6'b100010, 6'b101010, 6'b100101};
    alu = '{3'b110, 3'b111, 3'b001};
    seq = '{4'd0, 4'd1, 4'd6, 4'd7};
    bus.op = 6'b000000;
    for (int k = 0; k < 3; k++) begin
      bus.funct = fn[k];
      for (int i = 0; i < 4; i++) begin
        total++; if (bus.state !== seq[i]) $display("FAIL r_state[%0d.%0d] got=%0d exp=%0d", k, i, bus.state, seq[i]); else passed++;
        if (i == 2) begin
          total++; if (bus.alucontrol !== alu[k]) $display("FAIL r_alucontrol[%0d] got=%0b exp=%0b", k, bus.alucontrol, alu[k]); else passed++;
          total++; if (bus.alusrca !== 1'b1 || bus.alusrcb !== 2'b00) $display("FAIL r_alusrc got=%0b/%0b exp=1/00", bus.alusrca, bus.alusrcb); else passed++;
        end
        if (i == 3) begin
          total++; if (bus.regdst !== 1'b1 || bus.regwrite !== 1'b1) $display("FAIL r_aluwb got=%0b/%0b exp=1/1", bus.regdst, bus.regwrite); else passed++;
        end
        @(negedge clk);
      end
    end
    total++; if (bus.state !== 4'd0) $display("FAIL r_end_state got=%0d exp=0", bus.state); else passed++;
  endtask

  task automatic test_beq();
    logic z;
    bus.op = 6'b000100;
    for (int k = 0; k < 2; k++) begin
      z = (k == 0);
      total++; if (bus.state !== 4'd0) $display("FAIL beq_fetch[%0d] got=%0d exp=0", k, bus.state); else passed++;
      @(negedge clk);
      bus.zero = 1'b1;
      total++; if (bus.pcen !== 1'b0) $display("FAIL beq_decode_pcen got=%0b exp=0", bus.pcen); else passed++;
      bus.zero = z;
      @(negedge clk);
      total++; if (bus.state !== 4'd8) $display("FAIL beq_state[%0d] got=%0d exp=8", k, bus.state); else passed++;
      total++; if (bus.pcen !== z) $display("FAIL beq_pcen[%0d] got=%0b exp=%0b", k, bus.pcen, z); else passed++;
      total++; if (bus.pcsrc !== 2'b01) $display("FAIL beq_pcsrc got=%0b exp=01", bus.pcsrc); else passed++;
      total++; if (bus.alucontrol !== 3'b110) $display("FAIL beq_alucontrol got=%0b exp=110", bus.alucontrol); else passed++;
      bus.zero = ~z;
      #1;
      total++; if (bus.pcen !== ~z) $display("FAIL beq_pcen_follow[%0d] got=%0b exp=%0b", k, bus.pcen, ~z); else passed++;
      bus.zero = z;
      @(negedge clk);
    end
    bus.zero = 1'b0;
    total++; if (bus.state !== 4'd0) $display("FAIL beq_end_state got=%0d exp=0", bus.state); else passed++;
  endtask

  task automatic test_addi_jump();
    logic [3:0] seq [0:3];
    seq = '{4'd0, 4'd1, 4'd9, 4'd10};
    bus.op = 6'b001000;
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.state !== seq[i]) $display("FAIL addi_state[%0d] got=%0d exp=%0d", i, bus.state, seq[i]); else passed++;
      if (i == 2) begin
        total++; if (bus.alusrcb !== 2'b10) $display("FAIL addi_alusrcb got=%0b exp=10", bus.alusrcb); else passed++;
        total++; if (bus.alucontrol !== 3'b010) $display("FAIL addi_alucontrol got=%0b exp=010", bus.alucontrol); else passed++;
      end
      if (i == 3) begin
        total++; if (bus.regwrite !== 1'b1 || bus.regdst !== 1'b0 || bus.memtoreg !== 1'b0)
          $display("FAIL addi_wb got=%0b%0b%0b exp=100", bus.regwrite, bus.regdst, bus.memtoreg); else passed++;
      end
      @(negedge clk);
    end
    total++; if (bus.state !== 4'd0) $display("FAIL addi_end_state got=%0d exp=0", bus.state); else passed++;
    bus.op = 6'b000010;
    repeat (2) @(negedge clk);
    total++; if (bus.state !== 4'd11) $display("FAIL j_state got=%0d exp=11", bus.state); else passed++;
    total++; if (bus.pcsrc !== 2'b10) $display("FAIL j_pcsrc got=%0b exp=10", bus.pcsrc); else passed++;
    total++; if (bus.pcen !== 1'b1) $display("FAIL j_pcen got=%0b exp=1", bus.pcen); else passed++;
    total++; if (bus.irwrite !== 1'b0) $display("FAIL j_irwrite got=%0b exp=0", bus.irwrite); else passed++;
    @(negedge clk);
    total++; if (bus.state !== 4'd0) $display("FAIL j_end_state got=%0d exp=0", bus.state); else passed++;
  endtask

  task automatic test_illegal();
    bus.op = 6'b111111;
    @(negedge clk);
    total++; if (bus.state !== 4'd1) $display("FAIL ill_state got=%0d exp=1", bus.state); else passed++;
    total++; if ({bus.regwrite, bus.memwrite, bus.irwrite, bus.pcen} !== 4'b0000)
      $display("FAIL ill_strobes got=%0b exp=0000", {bus.regwrite, bus.memwrite, bus.irwrite, bus.pcen}); else passed++;
    @(negedge clk);
    total++; if (bus.state !== 4'd0) $display("FAIL ill_end_state got=%0d exp=0", bus.state); else passed++;
  endtask

  task automatic test_reset_mid();
    bus.op = 6'b100011;
    repeat (3) @(negedge clk);
    total++; if (bus.state !== 4'd3) $display("FAIL mid_memrd got=%0d exp=3", bus.state); else passed++;
    #2 reset = 1'b0;
    #1;
    total++; if (bus.state !== 4'd0) $display("FAIL mid_async_state got=%0d exp=0", bus.state); else passed++;
    total++; if (bus.irwrite !== 1'b1) $display("FAIL mid_irwrite got=%0b exp=1", bus.irwrite); else passed++;
    @(negedge clk);
    bus.op = 6'b111111;
    reset  = 1'b1;
    total++; if (bus.state !== 4'd0) $display("FAIL mid_held_state got=%0d exp=0", bus.state); else passed++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if (bus.regwrite !== 1'b0) $display("FAIL mid_regwrite[%0d] got=%0b exp=0", i, bus.regwrite); else passed++;
    end
    total++; if (bus.state !== 4'd0) $display("FAIL mid_after_state got=%0d exp=0", bus.state); else passed++;
    bus.op = 6'b101011;
    repeat (3) @(negedge clk);
    total++; if (bus.memwrite !== 1'b1) $display("FAIL mid_sw_memwrite got=%0b exp=1", bus.memwrite); else passed++;
    #2 reset = 1'b0;
    #1;
    total++; if (bus.memwrite !== 1'b0) $display("FAIL mid_sw_drop got=%0b exp=0", bus.memwrite); else passed++;
    total++; if (bus.state !== 4'd0) $display("FAIL mid_sw_state got=%0d exp=0", bus.state); else passed++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_beq();
    test_addi_jump();
    test_illegal();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control unit for the MIPS32 core. It is a Moore state machine that sequences each instruction through fetch, decode, execute, memory and writeback steps. Per cycle, it drives the datapath control strobes, from the opcode/funct fields of the instruction register and the ALU zero flag. It replaces the single-cycle combinational controller when the core shares one memory port between instruction and data accesses.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 forces state FETCH immediately
- op  in  6  instr[31:26] from instruction register
- funct  in  6  instr[5:0] from instruction register
- zero  in  1  ALU zero flag
- pcen  out  1  PC register enable = pcwrite | (branch & zero)
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register load
- regdst  out  1  write register: 0 = rt, 1 = rd
- memtoreg  out  1  writeback: 0 = ALUOut, 1 = memory data
- regwrite  out  1  register file write
- alusrca  out  1  ALU A: 0 = PC, 1 = rs
- alusrcb  out  2  ALU B: 00 rt, 01 constant 4, 10 signimm, 11 signimm<<2
- pcsrc  out  2  next PC: 00 ALU result, 01 ALUOut, 10 jump target
- alucontrol  out  3  ALU function
- state  out  4  current state encoding, for debug and verification

## Operation
- State register: 4 bits. Encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11
  - Encodings 12–15 go to FETCH on the next edge.
- Transitions:
  - FETCH→DECODE.
  - DECODE by op:
    - 100011 (lw) or 101011 (sw) → MEMADR
    - 000000 (R-type) → EXECUTE
    - 000100 (beq) → BRANCH
    - 001000 (addi) → ADDIEXEC
    - 000010 (j) → JUMP
    - any other op → FETCH (the instruction is a no-op; nothing is written)
  - MEMADR: lw → MEMRD, sw → MEMWR.
  - MEMRD→MEMWB.
  - EXECUTE→ALUWB.
  - ADDIEXEC→ADDIWB.
  - MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH and JUMP → FETCH.
- Outputs depend only on state; every signal not listed for a state is 0.
  - FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=1, pcwrite=1.
  - DECODE: alusrca=0, alusrcb=11, aluop=00 (branch target into ALUOut).
  - MEMADR: alusrca=1, alusrcb=10, aluop=00.
  - MEMRD: iord=1.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1.
  - EXECUTE: alusrca=1, alusrcb=00, aluop=10.
  - ALUWB: regdst=1, memtoreg=0, regwrite=1.
  - BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1.
  - ADDIEXEC: alusrca=1, alusrcb=10, aluop=00.
  - ADDIWB: regdst=0, memtoreg=0, regwrite=1.
  - JUMP: pcsrc=10, pcwrite=1.
- ALU decode (combinational from internal aluop and funct):
  - aluop 00 → 010 (add); aluop 01 → 110 (sub).
  - aluop 10, by funct:
    - 100000 → 010
    - 100010 → 110
    - 100100 → 000
    - 100101 → 001
    - 101010 → 111
    - unrecognised funct → 010
- pcen is combinational, so in BRANCH it follows zero within the same cycle.

## Timing
- While reset=0: state=FETCH and all outputs hold their FETCH values (irwrite=1, pcen=1, alusrcb=01, alucontrol=010, all others 0). The datapath registers are held in reset concurrently, so these strobes have no effect.
- First FETCH cycle is the first rising edge after reset deasserts.
- Cycles per instruction, FETCH inclusive: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unrecognised op 2.
- Write strobes (regwrite, memwrite, irwrite, pcen) are single-cycle pulses, active only in the states listed above.
- op and funct are read in DECODE and later states. The instruction register loads only at the end of FETCH, so both are stable from DECODE until the next FETCH.
- Reset asserted mid-instruction: state goes to FETCH asynchronously with no partial writeback. If reset hits MEMWR or a writeback state, the strobe drops in the same cycle.

## Test plan
- Reset: hold reset=0 for 3 cycles with op=101011 → state=0, irwrite=1, memwrite=0. Release → state sequence 0,1,2,5,0; memwrite=1 only in state 5, with iord=1.
- lw (op=100011) → states 0,1,2,3,4; MEMWB drives regwrite=1, memtoreg=1, regdst=0; lw again → 5-cycle period.
- R-type: op=000000 with funct=100010, then 101010, then 100101 → EXECUTE alucontrol=110, 111, 001 respectively; ALUWB regdst=1, regwrite=1.
- beq (op=000100): zero=1 → pcen=1, pcsrc=01 in BRANCH; zero=0 → pcen=0; next state FETCH in both cases.
- addi (op=001000) → states 0,1,9,10,0; ADDIEXEC alusrcb=10, alucontrol=010; j (op=000010) → JUMP pcsrc=10, pcen=1.
- op=111111 → 0,1,0 with no write strobes; reset pulsed during MEMRD → state=0 within the same cycle, and no regwrite pulse follows.
